// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants, FSM state type and index-width helper for serial_addsub32
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    function automatic int nib_idx_w(input int width);
        return $clog2(width / NIBBLE_W);
    endfunction

endpackage

// File: rtl/nibble_slice.sv
// rtl/nibble_slice.sv - combinational 4-bit ripple adder slice; c3 tap exists only with SERIAL_ADD_OVF_EN
module nibble_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic       c3
`endif
);

    logic [4:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
        end
    end

    assign co = w_c[4];

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the sign bit; XOR with co gives signed overflow on the top nibble.
    assign c3 = w_c[3];
`endif

endmodule

// File: rtl/serial_addsub32.sv
// rtl/serial_addsub32.sv - nibble-serial add/subtract unit with valid/ready handshakes; overflow flag via SERIAL_ADD_OVF_EN
module serial_addsub32
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int KW      = nib_idx_w(WIDTH);

    sa_state_t        r_state;
    sa_state_t        w_state_next;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;

    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;
    logic                w_last;
    logic                w_accept;
    logic [WIDTH-1:0]    w_res_next;

`ifdef SERIAL_ADD_OVF_EN
    logic w_c3;
    logic r_ovf;
`endif

    // Operands shift right one nibble per RUN cycle, so the slice always sees bits [3:0].
    nibble_slice u_slice (
        .x  (r_a[NIBBLE_W-1:0]),
        .y  (r_b[NIBBLE_W-1:0]),
        .ci (r_c),
        .s  (w_s),
        .co (w_co)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .c3 (w_c3)
`endif
    );

    assign w_last     = (r_k == KW'(NIBBLES - 1));
    assign w_accept   = in_valid && in_ready;
    assign w_res_next = {w_s, r_result[WIDTH-1:NIBBLE_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Result fills from the top; after NIBBLES shifts nibble 0 sits at bits [3:0].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_accept) begin
                r_a <= a;
                r_b <= b ^ {WIDTH{sub}};
                r_c <= sub;
                r_k <= '0;
            end else if (r_state == RUN) begin
                r_a      <= {{NIBBLE_W{1'b0}}, r_a[WIDTH-1:NIBBLE_W]};
                r_b      <= {{NIBBLE_W{1'b0}}, r_b[WIDTH-1:NIBBLE_W]};
                r_c      <= w_co;
                r_result <= w_res_next;
                if (w_last) begin
                    r_k    <= '0;
                    r_cout <= w_co;
                    r_zero <= (w_res_next == '0);
                end else begin
                    r_k <= r_k + KW'(1);
                end
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= w_c3 ^ w_co;
        end
    end

    assign overflow = r_ovf;
`endif

    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;

endmodule

// File: tb/tb_serial_addsub32.sv
// tb/tb_serial_addsub32.sv - directed self-checking bench for serial_addsub32
module tb_serial_addsub32;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        zero;
`ifdef SERIAL_ADD_OVF_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;

    serial_addsub32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                      input logic ts, input logic [31:0] er, input logic ec,
                      input logic ez, input logic eo);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        a        = ta;
        b        = tb_v;
        sub      = ts;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1357_9BDF;
        sub      = ~ts;
        wait_done(tag, 8);
        check({tag, "_result"}, result, er);
        check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, eo});
`else
        if (eo) begin
        end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_fall"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", {31'b0, overflow}, 32'd0);
`endif
        reset = 1'b0;
        #1;

        op("add_basic", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        op("sub_eq",    32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        op("sub_neg",   32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
        op("add_mix",   32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);

        // Backpressure: result held in DONE while new operands wait
        a        = 32'h0000_000A;
        b        = 32'h0000_0005;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        a        = 32'h0000_0001;
        b        = 32'h0000_0002;
        wait_done("bp_first", 8);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_result", result, 32'h0000_000F);
            check("bp_cout", {31'b0, cout}, 32'd0);
            check("bp_zero", {31'b0, zero}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", {31'b0, in_ready}, 32'd0);
        wait_done("bp_second", 8);
        check("bp_second_result", result, 32'h0000_0003);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while nibble 3 is being computed
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        op("post_rst_add", 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub32.md
# serial_addsub32

Nibble-serial 32-bit add/subtract unit for the multi-cycle datapath: accepts two operands over a valid/ready handshake and computes `a+b` or `a-b` one 4-bit slice per clock using a ripple nibble adder. It presents the result with carry and zero flags over a valid/ready output handshake. It sits between the operand register stage and the writeback mux. It trades latency for a single 4-bit carry chain in area-constrained builds.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of 4 and at least 8.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: unit can accept operands.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `sub` input 1: 1 selects `a-b`, 0 selects `a+b`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: sum or difference.
- `cout` output 1: carry out of the MSB. For subtract, 1 means no borrow (`a>=b` unsigned).
- `zero` output 1: `result==0`.
- `overflow` output 1: signed overflow. Present only with `SERIAL_ADD_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid&&in_ready`, latch `a`, `b^{WIDTH{sub}}` and carry register `c=sub`; set nibble index `k=0`; go to RUN.
- **RUN**
  - Each cycle the slice adds `a[4k+3:4k] + b'[4k+3:4k] + c`.
  - Its 4-bit sum is written to `result[4k+3:4k]` and its carry-out to `c`.
  - `k` increments each cycle.
  - After `k==WIDTH/4-1` is registered, go to DONE. In that same edge, `cout=c_final` and `zero` is computed from the full result.
- **DONE**
  - `out_valid=1`.
  - `result`, `cout`, `zero` and `overflow` are held stable while `out_ready=0`.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` is ignored there and causes no error.
- Operand inputs are sampled only at the accept edge. Later changes to `a`, `b` or `sub` do not affect the operation in flight.
- Subtract is two's-complement: invert B and inject carry 1. No separate borrow logic.
- `result` wraps modulo 2^WIDTH. The carry beyond the MSB appears only on `cout`.
- `zero` is driven from the completed result only. It is never updated from partial nibbles while `out_valid=1`.

## Timing
- **Reset** (sampled high at an edge; synchronous): state IDLE, `k=0`, `out_valid=0`, `result=0`, `cout=0`, `zero=0`, `overflow=0`.
- `in_ready=0` during any cycle in which `reset` is high.
- **Latency:** with the accept at edge E0, nibble k is registered at edge E(k+1). `out_valid` rises after edge E(WIDTH/4): 8 edges for WIDTH=32.
- **Throughput:** one operation per WIDTH/4+2 cycles with `out_ready` held high. There is no overlap of a new accept with the DONE→IDLE transition.
- **Reset mid-operation** (RUN or DONE): the operation is abandoned and no result is presented. The unit accepts again in the first cycle after `reset` falls.
- **Output handshake:** `out_valid` stays high until `out_ready` is sampled high. It then falls on the next edge.

## Configuration
- Macro `SERIAL_ADD_OVF_EN`.
- **Defined:**
  - The `overflow` port exists.
  - In the last RUN cycle, the slice also exposes its carry into bit 3 (`c3`).
  - `overflow = c3 ^ c_final`, registered alongside `cout` and reset to 0.
- **Undefined:** the port, the `c3` tap and the overflow register are absent. All other behaviour is identical.

## Structure
- **Package `serial_add_pkg`:**
  - `NIBBLE_W=4`.
  - State enum `sa_state_t` (IDLE, RUN, DONE).
  - Function giving the nibble-index width, `$clog2(WIDTH/4)`.
- **Sub-module `nibble_slice`:**
  - Combinational 4-bit ripple add.
  - Inputs `x[3:0]`, `y[3:0]`, `ci`.
  - Outputs `s[3:0]`, `co`, and `c3` (carry into bit 3).
  - The top level holds the FSM, the operand and result shift/index registers, and the flags.

## Test plan
- **Basic add:** `a=0x00000001`, `b=0x00000001`, `sub=0`. Expect `result=0x00000002`, `cout=0`, `zero=0`. `out_valid` rises exactly 8 edges after the accept.
- **Add with wrap:** `a=0xFFFFFFFF`, `b=0x00000001`, `sub=0`. Expect `result=0`, `cout=1`, `zero=1`, `overflow=0`.
- **Subtract:**
  - `a=5`, `b=5`: expect `result=0`, `cout=1`, `zero=1`.
  - `a=3`, `b=5`: expect `result=0xFFFFFFFE`, `cout=0`, `zero=0`.
- **Signed overflow** (macro defined): `a=0x7FFFFFFF`, `b=1`, `sub=0`. Expect `result=0x80000000`, `overflow=1`, `cout=0`.
  - `a=0x80000000`, `b=1`, `sub=1`: expect `result=0x7FFFFFFF`, `overflow=1`.
- **Backpressure:**
  - Hold `out_ready=0` for 5 cycles in DONE while `in_valid=1` with new operands.
  - Expect `result` and flags stable, `in_ready=0`, and the new operands not accepted.
  - Expect the second operation accepted only after the out handshake and return to IDLE.
- **Reset mid-RUN:**
  - Assert `reset` for one cycle while nibble 3 is in progress.
  - Expect `out_valid=0`, `result=0` and `in_ready=1` in the cycle after `reset` falls.
  - A following add of `0x10+0x20` returns `0x30`.
